// File: rtl/modport_lane_pkg.sv
// modport_lane_pkg
//   Shared constants and elaboration-time helpers for the modport lane bridge.
//   Contents:
//     LANES_DEFAULT  - default lane count (counter width / interface array size)
//     lane_identity  - constant identity function used to compute the index
//                      of the last lane outside the generate loop
package modport_lane_pkg;

    localparam int LANES_DEFAULT = 4;

    // Returns its argument unchanged. Its only use is in a localparam, so it
    // is evaluated during elaboration. The result therefore stays a constant
    // index into the interface array and does not become a runtime mux.
    function automatic integer lane_identity(input integer idx);
        return idx;
    endfunction

endpackage

// File: rtl/lane_if.sv
// lane_if
//   Single-bit lane carrying one signal, a.
//   Modports:
//     source - a is an output (the lane's single driver)
//     sink   - a is an input  (read-back side)
interface lane_if;

    logic a;

    modport source (output a);
    modport sink   (input  a);

endinterface

// File: rtl/modport_lane_link.sv
// modport_lane_link
//   Drives one lane through its source modport and returns the value seen on
//   the sink modport of the same lane.
//   Ports:
//     bit_i - value to drive onto the lane
//     src   - lane_if.source view (drives a)
//     snk   - lane_if.sink view (reads a)
//     bit_o - value read back from the sink side
module modport_lane_link (
    input  logic   bit_i,
    lane_if.source src,
    lane_if.sink   snk,
    output logic   bit_o
);

    assign src.a = bit_i;
    assign bit_o = snk.a;

endmodule

// File: rtl/modport_lane_bridge.sv
// modport_lane_bridge
//   N-lane loopback bridge. A free-running stimulus counter is carried to the
//   outputs over two paths: a plain wire (ack_out) and an array of single-bit
//   lane interfaces (a_out). The block compares the paths every clock, keeps
//   a sticky mismatch flag and flags counter saturation.
//   Ports:
//     clk      - rising-edge clock
//     rst      - synchronous, active-high reset
//     step_en  - advance the counter by one on this edge
//     count    - registered stimulus value
//     ack_out  - direct-path copy of count
//     a_out    - interface-path copy of count
//     mismatch - sticky: the two paths differed at a sampled edge
//     done     - high while count is all ones
module modport_lane_bridge
    import modport_lane_pkg::*;
#(
    parameter int N = LANES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step_en,
    output logic [N-1:0] count,
    output logic [N-1:0] ack_out,
    output logic [N-1:0] a_out,
    output logic         mismatch,
    output logic         done
);

    typedef logic [N-1:0] lane_vec_t;

    // The last lane sits outside the loop. Its index comes from the package
    // identity function and is fixed at elaboration.
    localparam int LAST = lane_identity(N - 1);

    lane_vec_t count_q, count_d;
    logic      mismatch_q, mismatch_d;

    lane_if lanes [N] ();

    for (genvar i = 0; i < N - 1; i++) begin : g_lane
        assign ack_out[i] = count_q[i];

        modport_lane_link u_link (
            .bit_i (count_q[i]),
            .src   (lanes[i]),
            .snk   (lanes[i]),
            .bit_o (a_out[i])
        );
    end

    assign ack_out[LAST] = count_q[LAST];

    modport_lane_link u_link_last (
        .bit_i (count_q[LAST]),
        .src   (lanes[LAST]),
        .snk   (lanes[LAST]),
        .bit_o (a_out[LAST])
    );

    always_comb begin
        count_d    = step_en ? count_q + lane_vec_t'(1) : count_q;
        mismatch_d = mismatch_q | (ack_out != a_out);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            mismatch_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign count    = count_q;
    assign mismatch = mismatch_q;
    assign done     = &count_q;

endmodule

// File: tb/tb_modport_lane_bridge.sv
// tb_modport_lane_bridge
//   Runs an N=4 and an N=6 bridge side by side from shared rst / step_en and
//   checks both against integer counter models: directed reset, sweep, wrap,
//   hold, mid-run reset and forced lane fault, then a randomized phase.
module tb_modport_lane_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic step_en = 1'b0;

    logic [3:0] count4, ack4, a4;
    logic       mm4, done4;
    logic [5:0] count6, ack6, a6;
    logic       mm6, done6;

    int total = 0;
    int bad   = 0;

    // Reference state
    int  m4 = 0;
    int  m6 = 0;
    bit  exp_mm4 = 1'b0;
    bit  fault4  = 1'b0;   // bench is forcing lane 3 of the N=4 bridge to 0

    always #5 clk = ~clk;

    modport_lane_bridge #(.N(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .step_en  (step_en),
        .count    (count4),
        .ack_out  (ack4),
        .a_out    (a4),
        .mismatch (mm4),
        .done     (done4)
    );

    modport_lane_bridge #(.N(6)) dut6 (
        .clk      (clk),
        .rst      (rst),
        .step_en  (step_en),
        .count    (count6),
        .ack_out  (ack6),
        .a_out    (a6),
        .mismatch (mm6),
        .done     (done6)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: apply model rules at the edge, compare on the falling edge.
    task automatic tick();
        int exp_a4;
        @(posedge clk);
        if (rst) begin
            m4 = 0;
            m6 = 0;
            exp_mm4 = 1'b0;
        end else begin
            // Fault only shows on lane 3, i.e. when bit 3 of count is set.
            if (fault4 && (m4 >= 8)) exp_mm4 = 1'b1;
            if (step_en) begin
                m4 = (m4 + 1) % 16;
                m6 = (m6 + 1) % 64;
            end
        end
        @(negedge clk);
        exp_a4 = fault4 ? (m4 % 8) : m4;
        check_val("count4",    64'(count4), 64'(m4));
        check_val("ack4",      64'(ack4),   64'(m4));
        check_val("a_out4",    64'(a4),     64'(exp_a4));
        check_val("done4",     64'(done4),  64'(m4 == 15));
        check_val("mismatch4", 64'(mm4),    64'(exp_mm4));
        check_val("count6",    64'(count6), 64'(m6));
        check_val("ack6",      64'(ack6),   64'(m6));
        check_val("a_out6",    64'(a6),     64'(m6));
        check_val("done6",     64'(done6),  64'(m6 == 63));
        check_val("mismatch6", 64'(mm6),    64'(0));
    endtask

    initial begin
        // Reset held two edges with step_en high, then release.
        @(negedge clk);
        rst = 1'b1;
        step_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_val("first_step", 64'(count4), 64'(1));

        // Sweep up to 15, then wrap to 0.
        for (int k = 0; k < 32 && m4 != 15; k++) tick();
        check_val("sat_done4", 64'(done4), 64'(1));
        tick();
        check_val("wrap_count4", 64'(count4), 64'(0));
        check_val("wrap_done4", 64'(done4), 64'(0));

        // Hold for three cycles.
        step_en = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check_val("hold_count4", 64'(count4), 64'(0));

        // Mid-run reset at count 9.
        step_en = 1'b1;
        for (int k = 0; k < 32 && m4 != 9; k++) tick();
        rst = 1'b1;
        tick();
        check_val("midrst_count4", 64'(count4), 64'(0));
        rst = 1'b0;
        tick();
        check_val("resume_count4", 64'(count4), 64'(1));

        // Lane 3 fault at count 8: force the read-back side low.
        for (int k = 0; k < 32 && m4 != 8; k++) tick();
        step_en = 1'b0;
        force dut4.a_out = 4'b0000;
        fault4 = 1'b1;
        tick();
        check_val("fault_mismatch4", 64'(mm4), 64'(1));
        release dut4.a_out;
        fault4 = 1'b0;
        step_en = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check_val("sticky_mismatch4", 64'(mm4), 64'(1));
        rst = 1'b1;
        tick();
        check_val("cleared_mismatch4", 64'(mm4), 64'(0));
        rst = 1'b0;

        // Full N=6 sweep from 0 through 63 and the wrap.
        for (int k = 0; k < 64; k++) tick();
        check_val("sweep6_wrap", 64'(count6), 64'(0));

        // Randomized enables with occasional resets.
        for (int k = 0; k < 300; k++) begin
            step_en = 1'($urandom_range(0, 3) != 0);
            rst     = 1'($urandom_range(0, 24) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the stimulus above ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit=%0d", 200000);
        $fatal(1);
    end

endmodule
